uart_tx_periph: RTL and testbench

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

---
 rtl/uart_tx_periph.sv | 274 +++++++++++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped UART transmitter with a small byte FIFO.
//
// Purpose
//   The pipeline MEM stage stores bytes to TXD. They queue in a FIFO and are
//   sent as 8N1 frames (start, 8 data bits LSB first, stop) on a serial line
//   that idles high. When the FIFO still holds data at the end of a stop bit,
//   the next frame follows with no idle gap. A store to a full FIFO is dropped
//   and sets a sticky overrun flag (OVR). Software clears OVR through CON.
//
// Register map (full 32-bit address decode)
//   0x4000_0018 TXD  write: push write_data[7:0]. Reads as 0.
//   0x4000_0020 CON  read : [0] full, [1] empty, [2] tx_active, [3] OVR,
//                           [8:4] occupancy, other bits 0.
//                    write: write_data[3]=1 clears OVR. Other bits are ignored.
//   Any other address: no effect, and read_data is 0.
//
// Bus handshake
//   mem_write and mem_read are single-cycle strobes qualified by addr.
//   There is no ready signal, so every access completes in its own cycle.
//   read_data is combinational from addr and mem_read.
//
// Build option
//   UART_PARITY_EN: when defined, an even-parity bit is inserted between
//   the data bits and the stop bit, giving an 11-bit frame.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (4..65535)
//   FIFO_DEPTH    FIFO entries, power of two (2..16)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   mem_write   store strobe
//   mem_read    load strobe
//   addr        byte address
//   write_data  store data
//   read_data   load data
//   tx          serial output (idle high)
//   tx_irq      registered; high while the FIFO is empty and the line is idle
//   state_dbg   current FSM state encoding
module uart_tx_periph #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        tx_irq,
    output logic [2:0]  state_dbg
);

    localparam logic [31:0] TXD_ADDR  = 32'h4000_0018;
    localparam logic [31:0] CON_ADDR  = 32'h4000_0020;
    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [15:0]        baud_cnt, baud_next;
    logic [2:0]         bit_cnt, bit_next;
    logic [7:0]         shreg, shreg_next;
    logic               load;
    logic               pop;
    logic               push;
    logic               ovr;
    logic               ovr_set;
    logic               ovr_clr;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_next;
    logic               full, empty;
    logic               tx_active;
    logic               baud_done;
    logic               txd_wr;
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic               unused_wdata;
`ifdef UART_PARITY_EN
    logic               parity_bit;
`endif

    assign unused_wdata = ^write_data[31:8];

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign tx_active = (state != IDLE);
    assign baud_done = (baud_cnt == BAUD_LAST);
    assign state_dbg = state;

    // A store to a full FIFO is accepted only when the FSM pops in that
    // same cycle. In that case the occupancy does not change.
    assign txd_wr  = mem_write && (addr == TXD_ADDR);
    assign push    = txd_wr && (!full || pop);
    assign ovr_set = txd_wr && full && !pop;
    assign ovr_clr = mem_write && (addr == CON_ADDR) && write_data[3];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // FIFO storage has no reset. Only the pointers and the count define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= write_data[7:0];
        end
    end

    // Next-state and line logic. Each state entry clears the baud and bit
    // counters, so frame timing never carries over from one frame to the next.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        load       = 1'b0;
        pop        = 1'b0;
        tx         = 1'b1;
        case (state)
            IDLE: begin
                tx = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = START;
                    baud_next  = '0;
                    bit_next   = '0;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_done) begin
                    state_next = DATA;
                    baud_next  = '0;
                    bit_next   = '0;
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                tx = shreg[0];
                if (baud_done) begin
                    baud_next  = '0;
                    shreg_next = shreg >> 1;
                    if (bit_cnt == 3'd7) begin
                        bit_next = '0;
`ifdef UART_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                tx = parity_bit;
                if (baud_done) begin
                    state_next = STOP;
                    baud_next  = '0;
                    bit_next   = '0;
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
`endif
            STOP: begin
                tx = 1'b1;
                if (baud_done) begin
                    baud_next = '0;
                    bit_next  = '0;
                    // If another byte is waiting, start it immediately.
                    if (!empty) begin
                        pop        = 1'b1;
                        load       = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
                bit_next   = '0;
            end
        endcase
        if (load) begin
            shreg_next = fifo_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovr      <= 1'b0;
            tx_irq   <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            count    <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
            // tx_irq is computed from the next state, so the registered
            // level matches the FIFO and FSM state of the same cycle.
            tx_irq <= (count_next == '0) && (state_next == IDLE);
        end
    end

`ifdef UART_PARITY_EN
    // Parity is taken from the byte when it is loaded. The shifter
    // changes during the frame, so it cannot be used here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_bit <= 1'b0;
        end else if (load) begin
            parity_bit <= ^fifo_mem[rd_ptr];
        end
    end
`endif

    always_comb begin
        read_data = '0;
        if (mem_read && (addr == CON_ADDR)) begin
            read_data[0]   = full;
            read_data[1]   = empty;
            read_data[2]   = tx_active;
            read_data[3]   = ovr;
            read_data[8:4] = 5'(count);
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: self-checking bench for uart_tx_periph.
// A frame-timeline model runs next to the DUT. It keeps a byte queue, plus
// a busy flag and a cycle position inside the current frame. From these it
// derives tx, tx_irq and the CON read value. On every falling edge, one
// compare process checks the DUT against the model. Directed sequences add
// hand-computed literal checks: bit patterns, latencies and CON values.
// Define UART_PARITY_EN to check the 11-bit frame build.
`timescale 1ns/1ps
module tb_uart_tx_periph;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] BITS_55 = 11'h4AA;
    localparam logic [10:0] BITS_07 = 11'h60E;
`else
    localparam int NB = 10;
    localparam logic [10:0] BITS_55 = 11'h2AA;
    localparam logic [10:0] BITS_07 = 11'h20E;
`endif
    localparam int FRAME = NB * CPB;
    localparam logic [31:0] TXD     = 32'h4000_0018;
    localparam logic [31:0] CON     = 32'h4000_0020;
    localparam logic [31:0] NOWHERE = 32'h4000_0000;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        tx;
    logic        tx_irq;
    logic [2:0]  state_unused;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_periph #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .tx         (tx),
        .tx_irq     (tx_irq),
        .state_dbg  (state_unused)
    );

    // ---------------- counters and check ----------------
    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] exp_q[$];
    bit         m_busy = 1'b0;
    int         m_pos  = 0;
    logic [7:0] m_cur  = '0;
    bit         m_ovr  = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_busy = 1'b0;
            m_pos  = 0;
            m_cur  = '0;
            m_ovr  = 1'b0;
        end else begin
            int sz;
            bit take;
            sz   = exp_q.size();
            take = 1'b0;
            if (!m_busy) begin
                if (sz > 0) begin
                    take   = 1'b1;
                    m_busy = 1'b1;
                    m_pos  = 0;
                end
            end else if (m_pos == FRAME - 1) begin
                if (sz > 0) begin
                    take  = 1'b1;
                    m_pos = 0;
                end else begin
                    m_busy = 1'b0;
                    m_pos  = 0;
                end
            end else begin
                m_pos++;
            end
            if (take) m_cur = exp_q.pop_front();
            if (mem_write && addr == TXD) begin
                if (sz < DEPTH || take) exp_q.push_back(write_data[7:0]);
                else m_ovr = 1'b1;
            end
            if (mem_write && addr == CON && write_data[3]) m_ovr = 1'b0;
        end
    end

    function automatic logic exp_tx();
        int b;
        if (!m_busy) return 1'b1;
        b = m_pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
`ifdef UART_PARITY_EN
        if (b == 9) return ^m_cur;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_read();
        logic [31:0] v;
        int sz;
        v  = '0;
        sz = exp_q.size();
        if (mem_read && addr == CON) begin
            v[0]   = (sz == DEPTH);
            v[1]   = (sz == 0);
            v[2]   = m_busy;
            v[3]   = m_ovr;
            v[8:4] = 5'(sz);
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_tx", tx, exp_tx());
            check("cyc_irq", tx_irq, (exp_q.size() == 0) && !m_busy);
            check("cyc_rdata", read_data, exp_read());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1; addr = a; write_data = d;
        @(posedge clk); #1;
        mem_write = 1'b0; addr = '0; write_data = '0;
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] v);
        mem_read = 1'b1; addr = a;
        #1;
        v = read_data;
        mem_read = 1'b0; addr = '0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_irq(input int bound);
        int n;
        n = 0;
        while (!tx_irq && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        check("irq_wait", tx_irq, 1'b1);
    endtask

    // Store one byte into an idle block and check the frame bit by bit,
    // sampling each bit at the middle of its period.
    task automatic frame_check(input logic [7:0] d, input logic [10:0] bits, input string nm);
        int s;
        do_store(TXD, {24'h0, d});
        check($sformatf("%s_pre", nm), tx, 1'b1);
        @(posedge clk); #1;
        s = cyc;
        check($sformatf("%s_start_lat", nm), tx, 1'b0);
        for (int i = 0; i < NB; i++) begin
            wait_cyc(s + CPB * i + CPB / 2);
            check($sformatf("%s_bit%0d", nm, i), tx, bits[i]);
            if (i == 4) check($sformatf("%s_irq_mid", nm), tx_irq, 1'b0);
        end
        wait_irq(2 * FRAME);
        check($sformatf("%s_frame_len", nm), cyc, s + FRAME);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] v;
        int s0;
        int lows;
        reset = 1'b0; mem_write = 1'b0; mem_read = 1'b0; addr = '0; write_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Values while reset is held.
        check("rst_tx", tx, 1'b1);
        check("rst_irq", tx_irq, 1'b1);
        read_reg(CON, v);
        check("rst_con", v, 32'h2);
        @(posedge clk); #1;
        reset = 1'b1;

        // No transmission after reset until a store arrives.
        lows = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (!tx) lows++;
        end
        check("idle_no_tx", lows, 0);
        check("idle_irq", tx_irq, 1'b1);

        // Single frames, with latency and bit order checked.
        frame_check(8'h55, BITS_55, "f55");
        frame_check(8'h07, BITS_07, "f07");

        // Overrun, OVR handling, full push+pop, back-to-back frames.
        do_store(TXD, 32'h3C);
        s0 = cyc + 1;
        repeat (3) begin @(posedge clk); #1; end
        do_store(TXD, 32'h11);
        do_store(TXD, 32'h22);
        do_store(TXD, 32'h33);
        do_store(TXD, 32'h44);
        do_store(TXD, 32'h66);
        read_reg(CON, v);
        check("ovr_full_con", v, 32'h4D);
        do_store(NOWHERE, 32'h08);
        read_reg(CON, v);
        check("nowhere_store_con", v, 32'h4D);
        read_reg(NOWHERE, v);
        check("nowhere_read", v, 32'h0);
        do_store(CON, 32'h07);
        read_reg(CON, v);
        check("con_no_clear", v, 32'h4D);
        do_store(CON, 32'h08);
        read_reg(CON, v);
        check("ovr_cleared", v, 32'h45);
        wait_cyc(s0 + FRAME - 1);
        do_store(TXD, 32'hC3);
        read_reg(CON, v);
        check("full_push_pop", v, 32'h45);
        wait_irq(7 * FRAME);
        check("b2b_six_frames", cyc, s0 + 6 * FRAME);

        // Occupancy after three stores into an idle block.
        do_store(TXD, 32'hA5);
        do_store(TXD, 32'h5A);
        do_store(TXD, 32'hF0);
        s0 = cyc - 1;
        read_reg(CON, v);
        check("occ_after_3", v, 32'h24);

        // Reset during data bit 3 of 0xA5 (bit value 0).
        wait_cyc(s0 + 4 * CPB + 5);
        check("data_b3_low", tx, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_tx", tx, 1'b1);
        check("rst_async_irq", tx_irq, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        read_reg(CON, v);
        check("rst_con_empty", v, 32'h2);
        lows = 0;
        repeat (2 * FRAME) begin
            @(posedge clk); #1;
            if (!tx) lows++;
        end
        check("post_rst_silent", lows, 0);

        // Unmapped accesses while idle.
        do_store(NOWHERE, 32'hFF);
        read_reg(TXD, v);
        check("txd_reads_zero", v, 32'h0);
        repeat (4) begin @(posedge clk); #1; end
        read_reg(CON, v);
        check("idle_con_final", v, 32'h2);
        check("idle_tx_final", tx, 1'b1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
